// File: rtl/axi_ic_pkg.sv
// Shared AXI constants and helpers for the round-robin interconnect.
package axi_ic_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/axi_rr_arb.sv
// Round-robin grant-and-lock arbiter for one AXI address channel.
module axi_rr_arb
  import axi_ic_pkg::*;
#(
  parameter int N  = 2,
  parameter int SB = 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [N-1:0]  req,
  input  logic          hs,
  output logic [SB-1:0] sel,
  output logic          locked
);
  arb_state_e    state_q;
  logic [SB-1:0] ptr_q, sel_q;
  logic [SB-1:0] pick, pick_lo, pick_hi;
  logic          found_hi;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    pick_lo  = '0;
    pick_hi  = '0;
    found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) pick_lo = SB'(i);
      if (req[i] && (SB'(i) >= ptr_q)) begin
        pick_hi  = SB'(i);
        found_hi = 1'b1;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: if (|req) begin
          sel_q   <= pick;
          state_q <= ARB_LOCK;
        end
        ARB_LOCK: if (hs) begin
          ptr_q   <= (sel_q == SB'(N - 1)) ? '0 : sel_q + SB'(1);
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign sel    = sel_q;
  assign locked = (state_q == ARB_LOCK);
endmodule

// File: rtl/axi_rr_interconnect.sv
// N:1 AXI3 interconnect: RR address arbitration, write-order FIFO for W steering,
// and ID-prefix routing of B/R responses back to the issuing upstream port.
module axi_rr_interconnect
  import axi_ic_pkg::*;
#(
  parameter int SLAVE_NUM   = 2,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int WFIFO_DEPTH = 4,
  localparam int SEL_BITS   = (clogb2(SLAVE_NUM) < 1) ? 1 : clogb2(SLAVE_NUM),
  localparam int MID_WIDTH  = ID_WIDTH + SEL_BITS,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [SLAVE_NUM-1:0][ID_WIDTH-1:0]    s_awid,
  input  logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [SLAVE_NUM-1:0][LEN_WIDTH-1:0]   s_awlen,
  input  logic [SLAVE_NUM-1:0][2:0]             s_awsize,
  input  logic [SLAVE_NUM-1:0][1:0]             s_awburst,
  input  logic [SLAVE_NUM-1:0]                  s_awvalid,
  output logic [SLAVE_NUM-1:0]                  s_awready,
  input  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]  s_wdata,
  input  logic [SLAVE_NUM-1:0][STRB_WIDTH-1:0]  s_wstrb,
  input  logic [SLAVE_NUM-1:0]                  s_wlast,
  input  logic [SLAVE_NUM-1:0]                  s_wvalid,
  output logic [SLAVE_NUM-1:0]                  s_wready,
  output logic [SLAVE_NUM-1:0][ID_WIDTH-1:0]    s_bid,
  output logic [SLAVE_NUM-1:0][1:0]             s_bresp,
  output logic [SLAVE_NUM-1:0]                  s_bvalid,
  input  logic [SLAVE_NUM-1:0]                  s_bready,
  input  logic [SLAVE_NUM-1:0][ID_WIDTH-1:0]    s_arid,
  input  logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]  s_araddr,
  input  logic [SLAVE_NUM-1:0][LEN_WIDTH-1:0]   s_arlen,
  input  logic [SLAVE_NUM-1:0][2:0]             s_arsize,
  input  logic [SLAVE_NUM-1:0][1:0]             s_arburst,
  input  logic [SLAVE_NUM-1:0]                  s_arvalid,
  output logic [SLAVE_NUM-1:0]                  s_arready,
  output logic [SLAVE_NUM-1:0][ID_WIDTH-1:0]    s_rid,
  output logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]  s_rdata,
  output logic [SLAVE_NUM-1:0][1:0]             s_rresp,
  output logic [SLAVE_NUM-1:0]                  s_rlast,
  output logic [SLAVE_NUM-1:0]                  s_rvalid,
  input  logic [SLAVE_NUM-1:0]                  s_rready,
  output logic [MID_WIDTH-1:0]                  m_awid,
  output logic [ADDR_WIDTH-1:0]                 m_awaddr,
  output logic [LEN_WIDTH-1:0]                  m_awlen,
  output logic [2:0]                            m_awsize,
  output logic [1:0]                            m_awburst,
  output logic                                  m_awvalid,
  input  logic                                  m_awready,
  output logic [MID_WIDTH-1:0]                  m_wid,
  output logic [DATA_WIDTH-1:0]                 m_wdata,
  output logic [STRB_WIDTH-1:0]                 m_wstrb,
  output logic                                  m_wlast,
  output logic                                  m_wvalid,
  input  logic                                  m_wready,
  input  logic [MID_WIDTH-1:0]                  m_bid,
  input  logic [1:0]                            m_bresp,
  input  logic                                  m_bvalid,
  output logic                                  m_bready,
  output logic [MID_WIDTH-1:0]                  m_arid,
  output logic [ADDR_WIDTH-1:0]                 m_araddr,
  output logic [LEN_WIDTH-1:0]                  m_arlen,
  output logic [2:0]                            m_arsize,
  output logic [1:0]                            m_arburst,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic [MID_WIDTH-1:0]                  m_rid,
  input  logic [DATA_WIDTH-1:0]                 m_rdata,
  input  logic [1:0]                            m_rresp,
  input  logic                                  m_rlast,
  input  logic                                  m_rvalid,
  output logic                                  m_rready
);
  localparam int PTR_W = (clogb2(WFIFO_DEPTH) < 1) ? 1 : clogb2(WFIFO_DEPTH);

  logic [SEL_BITS-1:0] aw_sel, ar_sel, head_sel, bk, rk;
  logic                aw_locked, ar_locked, aw_hs, ar_hs, wf_push, wf_pop;
  logic                wf_full, wf_empty, alive_q;
  logic [ID_WIDTH-1:0] head_id;

  logic [WFIFO_DEPTH-1:0][SEL_BITS-1:0] wf_sel_q;
  logic [WFIFO_DEPTH-1:0][ID_WIDTH-1:0] wf_id_q;
  logic [PTR_W-1:0]                     wf_wr_q, wf_rd_q;
  logic [PTR_W:0]                       wf_cnt_q, wf_cnt_d;

  axi_rr_arb #(.N(SLAVE_NUM), .SB(SEL_BITS)) u_aw_arb (
    .aclk(aclk), .aresetn(aresetn), .req(s_awvalid), .hs(aw_hs),
    .sel(aw_sel), .locked(aw_locked));

  axi_rr_arb #(.N(SLAVE_NUM), .SB(SEL_BITS)) u_ar_arb (
    .aclk(aclk), .aresetn(aresetn), .req(s_arvalid), .hs(ar_hs),
    .sel(ar_sel), .locked(ar_locked));

  // Response ready is held low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) alive_q <= 1'b0;
    else          alive_q <= 1'b1;

  // AW: a full order FIFO stalls the locked grant (registered full, no same-cycle bypass).
  assign m_awvalid = aw_locked & ~wf_full & s_awvalid[aw_sel];
  assign aw_hs     = m_awvalid & m_awready;
  assign m_awid    = {aw_sel, s_awid[aw_sel]};
  assign m_awaddr  = s_awaddr[aw_sel];
  assign m_awlen   = s_awlen[aw_sel];
  assign m_awsize  = s_awsize[aw_sel];
  assign m_awburst = s_awburst[aw_sel];

  always_comb begin
    s_awready = '0;
    if (aw_locked && !wf_full) s_awready[aw_sel] = m_awready;
  end

  assign m_arvalid = ar_locked & s_arvalid[ar_sel];
  assign ar_hs     = m_arvalid & m_arready;
  assign m_arid    = {ar_sel, s_arid[ar_sel]};
  assign m_araddr  = s_araddr[ar_sel];
  assign m_arlen   = s_arlen[ar_sel];
  assign m_arsize  = s_arsize[ar_sel];
  assign m_arburst = s_arburst[ar_sel];

  always_comb begin
    s_arready = '0;
    if (ar_locked) s_arready[ar_sel] = m_arready;
  end

  assign wf_full  = (wf_cnt_q == (PTR_W+1)'(WFIFO_DEPTH));
  assign wf_empty = (wf_cnt_q == '0);
  assign wf_push  = aw_hs;
  assign wf_pop   = m_wvalid & m_wready & m_wlast;

  always_comb begin
    wf_cnt_d = wf_cnt_q;
    case ({wf_push, wf_pop})
      2'b10:   wf_cnt_d = wf_cnt_q + 1'b1;
      2'b01:   wf_cnt_d = wf_cnt_q - 1'b1;
      default: wf_cnt_d = wf_cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wf_wr_q  <= '0;
      wf_rd_q  <= '0;
      wf_cnt_q <= '0;
    end else begin
      if (wf_push) wf_wr_q <= wf_wr_q + 1'b1;
      if (wf_pop)  wf_rd_q <= wf_rd_q + 1'b1;
      wf_cnt_q <= wf_cnt_d;
    end
  end

  always_ff @(posedge aclk)
    if (wf_push) begin
      wf_sel_q[wf_wr_q] <= aw_sel;
      wf_id_q[wf_wr_q]  <= s_awid[aw_sel];
    end

  // W is steered from the oldest write whose burst is still open.
  assign head_sel = wf_sel_q[wf_rd_q];
  assign head_id  = wf_id_q[wf_rd_q];
  assign m_wvalid = ~wf_empty & s_wvalid[head_sel];
  assign m_wid    = {head_sel, head_id};
  assign m_wdata  = s_wdata[head_sel];
  assign m_wstrb  = s_wstrb[head_sel];
  assign m_wlast  = s_wlast[head_sel];

  always_comb begin
    s_wready = '0;
    if (!wf_empty) s_wready[head_sel] = m_wready;
  end

  // Responses: ID prefix selects the port; an unknown prefix is drained.
  assign bk      = m_bid[MID_WIDTH-1 -: SEL_BITS];
  assign rk      = m_rid[MID_WIDTH-1 -: SEL_BITS];
  assign s_bid   = {SLAVE_NUM{m_bid[ID_WIDTH-1:0]}};
  assign s_bresp = {SLAVE_NUM{m_bresp}};
  assign s_rid   = {SLAVE_NUM{m_rid[ID_WIDTH-1:0]}};
  assign s_rdata = {SLAVE_NUM{m_rdata}};
  assign s_rresp = {SLAVE_NUM{m_rresp}};
  assign s_rlast = {SLAVE_NUM{m_rlast}};

  always_comb begin
    s_bvalid = '0;
    s_rvalid = '0;
    m_bready = alive_q;
    m_rready = alive_q;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (bk == SEL_BITS'(i)) begin
        s_bvalid[i] = m_bvalid & alive_q;
        m_bready    = s_bready[i] & alive_q;
      end
      if (rk == SEL_BITS'(i)) begin
        s_rvalid[i] = m_rvalid & alive_q;
        m_rready    = s_rready[i] & alive_q;
      end
    end
  end
endmodule
